pipe_hazard_ctrl: RTL

- Pipeline control unit. Generates the 2-bit `update` commands consumed by the F/D, D/E and E/W pipeline registers: 2'b00 hold, 2'b01 advance, 2'b10 flush to bubble.
- Resolves load-use stalls, taken-branch/jump redirects, multi-cycle execute ops (driven by the E-stage `counter` field) and the stop/resume halt.
- Sits beside the datapath. Inputs are D-stage operand info and E-stage pipeline-register outputs; outputs drive the pipeline registers and the PC enable.

---
 rtl/pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Pipeline control unit for a F/D -> D/E -> E/W pipeline. Generates the 2-bit
// update commands for the three pipeline registers (00 hold, 01 advance,
// 10 flush to bubble) and the PC enable / redirect. It resolves load-use
// stalls, taken-branch redirects, multi-cycle execute operations and the
// stop/resume halt.
//
// Outputs are combinational from the registered state, the down-counter and
// the inputs. Only the state and the counter are registered.
//
// Ports:
//   clk          clock, all state on the rising edge
//   rstn         asynchronous active-low reset
//   imem_ready   fetch stage holds a valid instruction
//   d_rs, d_rt   D-stage source registers; d_rs_used / d_rt_used qualify them
//   de_rd        E-stage destination register
//   de_rw        E-stage write kind: bit0 register write, bit1 load
//   de_counter   extra E cycles needed by the E instruction (0 = single cycle)
//   de_taken     E instruction is a taken branch / jump
//   de_stop      E instruction is stop
//   resume       leave HALT
//   fd_update, de_update, ew_update   pipeline register commands
//   pc_en        PC loads this cycle
//   pc_redirect  PC loads the E-stage target instead of PC+4
//   halted       controller is in HALT
//
// Optional feature (macro HAZ_PERF_EN): adds 32-bit saturating counters
//   perf_stall   cycles with pc_en=0 while not halted and out of reset
//   perf_flush   cycles with pc_redirect=1
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             imem_ready,
   input  logic [4:0]       d_rs,
   input  logic [4:0]       d_rt,
   input  logic             d_rs_used,
   input  logic             d_rt_used,
   input  logic [4:0]       de_rd,
   input  logic [1:0]       de_rw,
   input  logic [CNT_W-1:0] de_counter,
   input  logic             de_taken,
   input  logic             de_stop,
   input  logic             resume,
   output logic [1:0]       fd_update,
   output logic [1:0]       de_update,
   output logic [1:0]       ew_update,
   output logic             pc_en,
   output logic             pc_redirect,
   output logic             halted
`ifdef HAZ_PERF_EN
   ,
   output logic [31:0]      perf_stall,
   output logic [31:0]      perf_flush
`endif
);

   localparam logic [1:0] UPD_HOLD  = 2'b00;
   localparam logic [1:0] UPD_ADV   = 2'b01;
   localparam logic [1:0] UPD_FLUSH = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_MULTI = 2'd1,
      ST_HALT  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic load_use;
   logic decide;

   // A load whose result is needed by D cannot be forwarded until it reaches W.
   // Register 0 is hard-wired, so it never creates a dependency.
   assign load_use = de_rw[1] && (de_rd != 5'd0) &&
                     ((d_rs_used && (d_rs == de_rd)) ||
                      (d_rt_used && (d_rt == de_rd)));

   // The normal priority decision runs in RUN and in the last MULTI cycle.
   assign decide = (state_q == ST_RUN) ||
                   ((state_q == ST_MULTI) && (cnt_q == '0));

   always_comb begin
      // NOTE: every output and next-state variable gets a default first so no
      // path through the decision logic can leave one unassigned (no latches).
      state_d     = state_q;
      cnt_d       = cnt_q;
      fd_update   = UPD_HOLD;
      de_update   = UPD_HOLD;
      ew_update   = UPD_HOLD;
      pc_en       = 1'b0;
      pc_redirect = 1'b0;
      halted      = 1'b0;

      if (state_q == ST_HALT) begin
         ew_update = UPD_FLUSH;
         halted    = 1'b1;
         if (resume) state_d = ST_RUN;
      end else if (!decide) begin
         // Multi-cycle op still busy: freeze F/D and D/E, feed W bubbles.
         ew_update = UPD_FLUSH;
         cnt_d     = cnt_q - CNT_W'(1);
      end else begin
         state_d = ST_RUN;
         if (de_stop) begin
            de_update = UPD_FLUSH;
            ew_update = UPD_ADV;
            state_d   = ST_HALT;
         end else if ((state_q == ST_RUN) && (de_counter != '0)) begin
            // First E cycle of a multi-cycle op; the op is written back only
            // in its final cycle, so W receives a bubble now.
            ew_update = UPD_FLUSH;
            cnt_d     = de_counter - CNT_W'(1);
            state_d   = ST_MULTI;
         end else if (de_taken) begin
            fd_update   = UPD_FLUSH;
            de_update   = UPD_FLUSH;
            ew_update   = UPD_ADV;
            pc_en       = 1'b1;
            pc_redirect = 1'b1;
         end else if (load_use) begin
            de_update = UPD_FLUSH;
            ew_update = UPD_ADV;
         end else if (!imem_ready) begin
            fd_update = UPD_FLUSH;
            de_update = UPD_ADV;
            ew_update = UPD_ADV;
         end else begin
            fd_update = UPD_ADV;
            de_update = UPD_ADV;
            ew_update = UPD_ADV;
            pc_en     = 1'b1;
         end
      end

      // Outputs are forced quiet while reset is asserted, independent of the
      // inputs, so nothing moves until the reset is released.
      if (!rstn) begin
         fd_update   = UPD_HOLD;
         de_update   = UPD_HOLD;
         ew_update   = UPD_HOLD;
         pc_en       = 1'b0;
         pc_redirect = 1'b0;
         halted      = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // values from before the clock edge, independent of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZ_PERF_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_flush_q, perf_flush_d;

   always_comb begin
      perf_stall_d = perf_stall_q;
      perf_flush_d = perf_flush_q;
      if (rstn && !pc_en && !halted && (perf_stall_q != 32'hFFFF_FFFF))
         perf_stall_d = perf_stall_q + 32'd1;
      if (pc_redirect && (perf_flush_q != 32'hFFFF_FFFF))
         perf_flush_d = perf_flush_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
      end
   end

   assign perf_stall = perf_stall_q;
   assign perf_flush = perf_flush_q;
`endif

endmodule
